// File: rtl/odd_seq_checker.sv
`default_nettype none
// ============================================================================
// odd_seq_checker : receive-side monitor for the odd-counter stream.
// Rev 1.0
// ============================================================================
module odd_seq_checker #(
  parameter int WIDTH    = 8,
  parameter int STEP     = 2,
  parameter int LOCK_CNT = 4,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] cnt_i,
  input  logic             clear,
  output logic             locked,
  output logic             err_pulse,
  output logic [1:0]       err_code,
  output logic [CNT_W-1:0] err_cnt,
  output logic [CNT_W-1:0] match_cnt,
  output logic [WIDTH-1:0] expected_o
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ACQUIRE = 2'd1,
    S_LOCKED  = 2'd2
  } state_t;

  localparam logic [1:0]       c_code_none   = 2'd0;
  localparam logic [1:0]       c_code_parity = 2'd1;
  localparam logic [1:0]       c_code_seq    = 2'd2;
  localparam logic [CNT_W-1:0] c_cnt_max     = {CNT_W{1'b1}};

  state_t           state_q, state_d;
  logic [7:0]       run_q, run_d;
  logic [WIDTH-1:0] expected_q, expected_d;
  logic             locked_q, locked_d;
  logic             err_pulse_q, err_pulse_d;
  logic [1:0]       err_code_q, err_code_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic [CNT_W-1:0] match_cnt_q, match_cnt_d;

  logic             w_odd;
  logic             w_err_inc;
  logic             w_match_inc;
  logic [WIDTH-1:0] w_seed_next;
  logic [WIDTH-1:0] w_exp_adv;
  logic [7:0]       w_run_inc;

  assign w_odd       = cnt_i[0];
  assign w_seed_next = cnt_i + WIDTH'(STEP);
  assign w_exp_adv   = expected_q + WIDTH'(STEP);
  assign w_run_inc   = run_q + 8'd1;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      run_q       <= '0;
      expected_q  <= '0;
      locked_q    <= 1'b0;
      err_pulse_q <= 1'b0;
      err_code_q  <= c_code_none;
      err_cnt_q   <= '0;
      match_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      run_q       <= run_d;
      expected_q  <= expected_d;
      locked_q    <= locked_d;
      err_pulse_q <= err_pulse_d;
      err_code_q  <= err_code_d;
      err_cnt_q   <= err_cnt_d;
      match_cnt_q <= match_cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    run_d       = run_q;
    expected_d  = expected_q;
    locked_d    = locked_q;
    err_pulse_d = 1'b0;
    err_code_d  = c_code_none;
    w_err_inc   = 1'b0;
    w_match_inc = 1'b0;

    if (in_valid) begin
      // Parity is checked first in every state, so an even value is never a sequence error.
      if (!w_odd) begin
        state_d     = S_IDLE;
        run_d       = '0;
        expected_d  = '0;
        locked_d    = 1'b0;
        err_pulse_d = 1'b1;
        err_code_d  = c_code_parity;
        w_err_inc   = 1'b1;
      end else begin
        case (state_q)
          S_IDLE: begin
            state_d    = S_ACQUIRE;
            run_d      = 8'd1;
            expected_d = w_seed_next;
          end
          S_ACQUIRE: begin
            if (cnt_i == expected_q) begin
              run_d      = w_run_inc;
              expected_d = w_exp_adv;
              if (w_run_inc == 8'(LOCK_CNT)) begin
                state_d  = S_LOCKED;
                locked_d = 1'b1;
              end
            end else begin
              run_d      = 8'd1;
              expected_d = w_seed_next;
            end
          end
          S_LOCKED: begin
            if (cnt_i == expected_q) begin
              expected_d  = w_exp_adv;
              w_match_inc = 1'b1;
            end else begin
              state_d     = S_ACQUIRE;
              run_d       = 8'd1;
              expected_d  = w_seed_next;
              locked_d    = 1'b0;
              err_pulse_d = 1'b1;
              err_code_d  = c_code_seq;
              w_err_inc   = 1'b1;
            end
          end
          default: begin
            state_d    = S_IDLE;
            run_d      = '0;
            expected_d = '0;
            locked_d   = 1'b0;
          end
        endcase
      end
    end

    err_cnt_d   = (w_err_inc && err_cnt_q != c_cnt_max) ? err_cnt_q + CNT_W'(1) : err_cnt_q;
    match_cnt_d = (w_match_inc && match_cnt_q != c_cnt_max) ? match_cnt_q + CNT_W'(1) : match_cnt_q;

    // Soft clear wins over any sample offered on the same edge.
    if (clear) begin
      state_d     = S_IDLE;
      run_d       = '0;
      expected_d  = '0;
      locked_d    = 1'b0;
      err_pulse_d = 1'b0;
      err_code_d  = c_code_none;
      err_cnt_d   = '0;
      match_cnt_d = '0;
    end
  end

  assign locked     = locked_q;
  assign err_pulse  = err_pulse_q;
  assign err_code   = err_code_q;
  assign err_cnt    = err_cnt_q;
  assign match_cnt  = match_cnt_q;
  assign expected_o = expected_q;

endmodule
`default_nettype wire

// File: tb/tb_odd_seq_checker.sv
`default_nettype none
// ============================================================================
// tb_odd_seq_checker : scoreboard bench with directed vectors for odd_seq_checker.
// Rev 1.0
// ============================================================================
module tb_odd_seq_checker;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic [7:0]  cnt_i;
  logic        clear;
  logic        locked;
  logic        err_pulse;
  logic [1:0]  err_code;
  logic [15:0] err_cnt;
  logic [15:0] match_cnt;
  logic [7:0]  expected_o;

  odd_seq_checker #(.WIDTH(8), .STEP(2), .LOCK_CNT(4), .CNT_W(16)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .cnt_i      (cnt_i),
    .clear      (clear),
    .locked     (locked),
    .err_pulse  (err_pulse),
    .err_code   (err_code),
    .err_cnt    (err_cnt),
    .match_cnt  (match_cnt),
    .expected_o (expected_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        lk;
    logic        ep;
    logic [1:0]  ec;
    logic [15:0] ecnt;
    logic [15:0] mcnt;
    logic [7:0]  ex;
    bit          chk;
    string       tag;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   total = 0;
  int   bad   = 0;

  // Inputs change on the falling edge; the matching expectation is queued for the next rising edge.
  task automatic drive(input bit v, input logic [7:0] c, input bit clr, input bit rst,
                       input logic lk, input logic ep, input logic [1:0] ec,
                       input logic [15:0] ecnt, input logic [15:0] mcnt, input logic [7:0] ex,
                       input bit chk, input string tag);
    exp_t x;
    @(negedge clk);
    in_valid = v;
    cnt_i    = c;
    clear    = clr;
    reset    = rst;
    x.lk = lk; x.ep = ep; x.ec = ec; x.ecnt = ecnt; x.mcnt = mcnt; x.ex = ex;
    x.chk = chk; x.tag = tag;
    sb.push_back(x);
  endtask

  always @(posedge clk) begin
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      if (e.chk) begin
        total = total + 1;
        if ({locked, err_pulse, err_code, err_cnt, match_cnt, expected_o} !==
            {e.lk, e.ep, e.ec, e.ecnt, e.mcnt, e.ex}) begin
          bad = bad + 1;
          $display("FAIL %s: got lk=%b ep=%b ec=%0d ecnt=%0d mcnt=%0d ex=%0d want lk=%b ep=%b ec=%0d ecnt=%0d mcnt=%0d ex=%0d",
                   e.tag, locked, err_pulse, err_code, err_cnt, match_cnt, expected_o,
                   e.lk, e.ep, e.ec, e.ecnt, e.mcnt, e.ex);
        end
      end
    end
  end

  initial begin
    logic [15:0] mc;
    logic [15:0] ec_exp;
    reset = 1'b1; clear = 1'b0; in_valid = 1'b0; cnt_i = 8'd0;

    for (int i = 0; i < 5; i++)
      drive(1'b1, 8'd3, 1'b0, 1'b1, 0, 0, 2'd0, 16'd0, 16'd0, 8'd0, 1, "reset");

    // Seed and acquire lock
    drive(1, 8'd1, 0, 0, 0, 0, 2'd0, 16'd0, 16'd0, 8'd3, 1, "seed1");
    drive(1, 8'd3, 0, 0, 0, 0, 2'd0, 16'd0, 16'd0, 8'd5, 1, "acq3");
    drive(1, 8'd5, 0, 0, 0, 0, 2'd0, 16'd0, 16'd0, 8'd7, 1, "acq5");
    drive(1, 8'd7, 0, 0, 1, 0, 2'd0, 16'd0, 16'd0, 8'd9, 1, "lock7");

    // Locked run through the 8-bit wrap
    mc = 16'd0;
    for (int v = 9; v <= 255; v += 2) begin
      mc = mc + 16'd1;
      drive(1, 8'(v), 0, 0, 1, 0, 2'd0, 16'd0, mc, 8'(v + 2), 1, "run");
    end
    drive(1, 8'd1, 0, 0, 1, 0, 2'd0, 16'd0, 16'd125, 8'd3, 1, "wrap1");
    drive(1, 8'd3, 0, 0, 1, 0, 2'd0, 16'd0, 16'd126, 8'd5, 1, "wrap3");
    drive(1, 8'd5, 0, 0, 1, 0, 2'd0, 16'd0, 16'd127, 8'd7, 1, "run5");
    drive(1, 8'd7, 0, 0, 1, 0, 2'd0, 16'd0, 16'd128, 8'd9, 1, "run7");
    drive(1, 8'd9, 0, 0, 1, 0, 2'd0, 16'd0, 16'd129, 8'd11, 1, "run9");

    // Sequence error and relock
    drive(1, 8'd15, 0, 0, 0, 1, 2'd2, 16'd1, 16'd129, 8'd17, 1, "seqerr");
    drive(1, 8'd17, 0, 0, 0, 0, 2'd0, 16'd1, 16'd129, 8'd19, 1, "reacq17");
    drive(1, 8'd19, 0, 0, 0, 0, 2'd0, 16'd1, 16'd129, 8'd21, 1, "reacq19");
    drive(1, 8'd21, 0, 0, 1, 0, 2'd0, 16'd1, 16'd129, 8'd23, 1, "relock21");

    // Parity errors in LOCKED and IDLE, then pulse drop on an idle cycle
    drive(1, 8'd8,  0, 0, 0, 1, 2'd1, 16'd2, 16'd129, 8'd0, 1, "par_locked");
    drive(1, 8'd10, 0, 0, 0, 1, 2'd1, 16'd3, 16'd129, 8'd0, 1, "par_idle");
    drive(0, 8'd12, 0, 0, 0, 0, 2'd0, 16'd3, 16'd129, 8'd0, 1, "pulse_drop");

    // Gaps with in_valid low
    drive(1, 8'd1, 0, 0, 0, 0, 2'd0, 16'd3, 16'd129, 8'd3, 1, "gap_seed");
    drive(1, 8'd3, 0, 0, 0, 0, 2'd0, 16'd3, 16'd129, 8'd5, 1, "gap_3");
    drive(0, 8'd2, 0, 0, 0, 0, 2'd0, 16'd3, 16'd129, 8'd5, 1, "gap_a");
    drive(0, 8'd9, 0, 0, 0, 0, 2'd0, 16'd3, 16'd129, 8'd5, 1, "gap_b");
    drive(1, 8'd5, 0, 0, 0, 0, 2'd0, 16'd3, 16'd129, 8'd7, 1, "gap_5");
    drive(1, 8'd7, 0, 0, 1, 0, 2'd0, 16'd3, 16'd129, 8'd9, 1, "gap_lock7");

    // Reset with clear and a valid sample, then clear alone
    drive(1, 8'd9, 1, 1, 0, 0, 2'd0, 16'd0, 16'd0, 8'd0, 1, "rst_clr");
    drive(1, 8'd1, 0, 0, 0, 0, 2'd0, 16'd0, 16'd0, 8'd3, 1, "post_rst");
    drive(1, 8'd3, 0, 0, 0, 0, 2'd0, 16'd0, 16'd0, 8'd5, 1, "post_rst3");
    drive(1, 8'd5, 1, 0, 0, 0, 2'd0, 16'd0, 16'd0, 8'd0, 1, "clear");

    // Silent reseed in ACQUIRE, then parity error in ACQUIRE
    drive(1, 8'd1,  0, 0, 0, 0, 2'd0, 16'd0, 16'd0, 8'd3, 1, "acq_seed");
    drive(1, 8'd3,  0, 0, 0, 0, 2'd0, 16'd0, 16'd0, 8'd5, 1, "acq_ok");
    drive(1, 8'd11, 0, 0, 0, 0, 2'd0, 16'd0, 16'd0, 8'd13, 1, "acq_reseed");
    drive(1, 8'd4,  0, 0, 0, 1, 2'd1, 16'd1, 16'd0, 8'd0, 1, "acq_par");

    // Saturation of err_cnt with repeated even samples
    ec_exp = 16'd1;
    for (int i = 0; i < 65540; i++) begin
      if (ec_exp != 16'hFFFF) ec_exp = ec_exp + 16'd1;
      drive(1, 8'd2, 0, 0, 0, 1, 2'd1, ec_exp, 16'd0, 8'd0, (i >= 65530), "saturate");
    end
    drive(0, 8'd0, 0, 0, 0, 0, 2'd0, 16'hFFFF, 16'd0, 8'd0, 1, "sat_hold");

    @(negedge clk);
    @(negedge clk);
    total = total + 1;
    if (sb.size() != 0) begin
      bad = bad + 1;
      $display("FAIL drain: got %0d pending entries, want 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
